// File: rtl/ss_product_decoder.sv
// ss_product_decoder
//  Frames the per-cycle stochastic-symbol product stream into windows of 2^LOG_LEN valid
//  symbols and returns each window as a raw sum plus a round-half-up mean through a
//  valid/ready output register.
// Ports
//  clk        rising-edge clock
//  rst        asynchronous, active-low reset
//  start      pulse: begin (or restart) a window
//  ss_valid   ss_in carries a symbol this cycle
//  ss_in      unsigned SS product symbol
//  busy       decoder is not idle
//  out_valid  z_sum/z_mean hold an unconsumed result
//  out_ready  downstream accepts the result
//  z_sum      raw window sum
//  z_mean     rounded window mean
//  overrun    sticky: a symbol was dropped while waiting to unload
module ss_product_decoder #(
   parameter int unsigned SS_W    = 8,
   parameter int unsigned LOG_LEN = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    ss_valid,
   input  logic [SS_W-1:0]         ss_in,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SS_W+LOG_LEN-1:0] z_sum,
   output logic [SS_W-1:0]         z_mean,
   output logic                    overrun
);

   localparam int unsigned ACC_W = SS_W + LOG_LEN;
   localparam logic [LOG_LEN-1:0] CNT_LAST = '1;
   localparam logic [ACC_W-1:0]   HALF     = ACC_W'(1) << (LOG_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [ACC_W-1:0]   acc, acc_n;
   logic [LOG_LEN-1:0] cnt, cnt_n;
   logic               overrun_n;
   logic               out_valid_n;
   logic [ACC_W-1:0]   z_sum_n;
   logic [SS_W-1:0]    z_mean_n;
   logic [ACC_W-1:0]   acc_rnd;
   logic               out_free;

   // Rounding bias cannot overflow: the largest window sum leaves room for half an LSB of the mean.
   assign acc_rnd  = acc + HALF;
   assign out_free = ~out_valid | out_ready;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Next-state and datapath decode
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      cnt_n       = cnt;
      overrun_n   = overrun;
      z_sum_n     = z_sum;
      z_mean_n    = z_mean;
      // A handshake drains the output register unless a load below refills it.
      out_valid_n = out_valid & ~out_ready;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n   = ACCUM;
               acc_n     = '0;
               cnt_n     = '0;
               overrun_n = 1'b0;
            end
         end
         ACCUM: begin
            if (start) begin
               // Restart discards the partial window and this cycle's symbol.
               acc_n     = '0;
               cnt_n     = '0;
               overrun_n = 1'b0;
            end else if (ss_valid) begin
               acc_n = acc + ACC_W'(ss_in);
               cnt_n = cnt + LOG_LEN'(1);
               if (cnt == CNT_LAST) state_n = DONE;
            end
         end
         DONE: begin
            if (out_free) begin
               z_sum_n     = acc;
               z_mean_n    = SS_W'(acc_rnd >> LOG_LEN);
               out_valid_n = 1'b1;
               state_n     = IDLE;
            end else if (ss_valid) begin
               overrun_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         cnt       <= '0;
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         z_sum     <= '0;
         z_mean    <= '0;
         busy      <= 1'b0;
      end else begin
         acc       <= acc_n;
         cnt       <= cnt_n;
         overrun   <= overrun_n;
         out_valid <= out_valid_n;
         z_sum     <= z_sum_n;
         z_mean    <= z_mean_n;
         busy      <= (state_n != IDLE);
      end
   end

endmodule
